// File: rtl/eda_fifo_arbiter.sv
// Pop scheduler for the 8-entry neighbour-FIFO bank of the regional-max flood-fill.
// Define EDA_FIFO_ARB_FIXED_PRI_EN for fixed priority (7 high .. 0 low) instead of round-robin.
module eda_fifo_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_DIR    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_DIR-1:0]            fifo_empty,
    input  logic [ADDR_WIDTH*NUM_DIR-1:0] fifo_data,
    output logic [NUM_DIR-1:0]            read_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [2:0]                    out_dir,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        POP,
        CAPT,
        OUT
    } state_t;

    state_t     state;
    logic [2:0] win;
    logic [2:0] pick;
    logic       found;

`ifdef EDA_FIFO_ARB_FIXED_PRI_EN
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            if (!found && !fifo_empty[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [2:0] rr_ptr;
    logic [2:0] idx;

    // Search descends from rr_ptr-1; the last-served FIFO is tried last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            idx = rr_ptr - 3'(k);
            if (!found && !fifo_empty[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            read_en   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_dir   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win       <= '0;
`ifndef EDA_FIFO_ARB_FIXED_PRI_EN
            rr_ptr    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            read_en <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!found) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        win           <= pick;
                        read_en[pick] <= 1'b1;
                        state         <= POP;
                    end
                end
                POP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_addr  <= fifo_data[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    out_dir   <= win;
                    out_valid <= 1'b1;
`ifndef EDA_FIFO_ARB_FIXED_PRI_EN
                    rr_ptr    <= win;
`endif
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= SCAN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eda_fifo_arbiter.sv
// Directed bench for eda_fifo_arbiter with a registered-read FIFO bank model.
module tb_eda_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  fifo_empty;
    logic [95:0] fifo_data = '0;
    logic [7:0]  read_en;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_addr;
    logic [2:0]  out_dir;
    logic        busy;
    logic        done;

    int ncomp = 0;
    int nerr = 0;

    logic [11:0] mem [8][8];
    int wr [8] = '{default: 0};
    int rd [8] = '{default: 0};

    eda_fifo_arbiter dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .read_en(read_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_dir(out_dir),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = '0;
        for (int i = 0; i < 8; i++) fifo_empty[i] = (wr[i] == rd[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (read_en[i]) begin
                fifo_data[i*12 +: 12] <= mem[i][rd[i] % 8];
                rd[i] <= rd[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [11:0] v);
        mem[d][wr[d] % 8] = v;
        wr[d] = wr[d] + 1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_grant(input logic [2:0] d, input logic [11:0] a);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (read_en != 0) ok = 1'b1;
        end
        chk("grant_seen", 32'(ok), 1);
        chk("read_en", 32'(read_en), 32'd1 << d);
        @(negedge clk);
        chk("read_en_1cyc", 32'(read_en), 0);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (out_valid) ok = 1'b1;
            else @(negedge clk);
        end
        chk("valid_seen", 32'(ok), 1);
        chk("out_addr", 32'(out_addr), 32'(a));
        chk("out_dir", 32'(out_dir), 32'(d));
    endtask

    task automatic expect_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        chk("done_seen", 32'(ok), 1);
        chk("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        chk("done_1cyc", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        @(negedge clk);
        chk("rst_read_en", 32'(read_en), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_dir", 32'(out_dir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: empty drain
        do_start();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_rd0", 32'(read_en), 0);
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_rd1", 32'(read_en), 0);
        @(negedge clk);
        chk("t1_done_low", 32'(done), 0);

        // 2: single entry, exact timing
        push(3, 12'h0A5);
        do_start();
        chk("t2_scan_rd", 32'(read_en), 0);
        @(negedge clk);
        chk("t2_pop_rd", 32'(read_en), 32'h08);
        @(negedge clk);
        chk("t2_capt_rd", 32'(read_en), 0);
        chk("t2_capt_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_addr", 32'(out_addr), 32'h0A5);
        chk("t2_dir", 32'(out_dir), 3);
        @(negedge clk);
        chk("t2_valid_low", 32'(out_valid), 0);
        @(negedge clk);
        chk("t2_done", 32'(done), 1);

        // 3: two FIFOs, two entries each, from a fresh pointer
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(7, 12'h701);
        push(7, 12'h702);
        push(2, 12'h201);
        push(2, 12'h202);
        do_start();
`ifdef EDA_FIFO_ARB_FIXED_PRI_EN
        expect_grant(3'd7, 12'h701);
        expect_grant(3'd7, 12'h702);
        expect_grant(3'd2, 12'h201);
        expect_grant(3'd2, 12'h202);
`else
        expect_grant(3'd7, 12'h701);
        expect_grant(3'd2, 12'h201);
        expect_grant(3'd7, 12'h702);
        expect_grant(3'd2, 12'h202);
`endif
        expect_done();

        // 4: backpressure with a live push during the stall
        out_ready = 1'b0;
        push(5, 12'h123);
        do_start();
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (read_en != 0) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t4_grant_seen", 32'(ok), 1);
        chk("t4_read_en", 32'(read_en), 32'h20);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        chk("t4_valid_seen", 32'(ok), 1);
        push(0, 12'h0F0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_addr", 32'(out_addr), 32'h123);
            chk("t4_hold_dir", 32'(out_dir), 5);
            chk("t4_hold_rd", 32'(read_en), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expect_grant(3'd0, 12'h0F0);
        expect_done();

        // 5: pointer at 0 wraps to 7 first
        push(7, 12'h777);
        push(1, 12'h111);
        do_start();
        expect_grant(3'd7, 12'h777);
        expect_grant(3'd1, 12'h111);
        expect_done();

        // 6: asynchronous reset while holding an entry
        out_ready = 1'b0;
        push(4, 12'h444);
        push(4, 12'h445);
        do_start();
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        chk("t6_valid_seen", 32'(ok), 1);
        chk("t6_addr", 32'(out_addr), 32'h444);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_addr", 32'(out_addr), 0);
        chk("t6_async_dir", 32'(out_dir), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_rd", 32'(read_en), 0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_rd", 32'(read_en), 0);
        do_start();
        expect_grant(3'd4, 12'h445);
        expect_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
        $finish;
    end

endmodule
